// File: rtl/apb_master.sv
// APB3 requester: valid/ready command in, IDLE/SETUP/ACCESS transfers out, one-cycle response strobe.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;
  logic                accept;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("apb_master: TIMEOUT must be at least 1");
  end

  assign cmd_ready = (state_q == S_IDLE) | ((state_q == S_ACCESS) & pready);
  assign accept    = cmd_valid & cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             timeout_hit;

  // The stalled cycle that would bring the count to TIMEOUT is the last one.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    if (accept) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      if (cmd_write) begin
        pwdata_d = cmd_wdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = pwrite_q ? '0 : prdata;
          rsp_slverr_d = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          penable_d = 1'b0;
          if (accept) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
            psel_d  = 1'b0;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (timeout_hit) begin
            state_d       = S_IDLE;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q      <= S_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule
